// File: rtl/ripemd160_pkg.sv
// Shared constants, schedule tables and round helpers for the RIPEMD-160 line cores.
package ripemd160_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    localparam logic [31:0] IvA = 32'h67452301;
    localparam logic [31:0] IvB = 32'hEFCDAB89;
    localparam logic [31:0] IvC = 32'h98BADCFE;
    localparam logic [31:0] IvD = 32'h10325476;
    localparam logic [31:0] IvE = 32'hC3D2E1F0;

    localparam logic [6:0] LastRound = 7'd79;

    // Schedule tables, one hex digit per round, round 0 is the leftmost digit.
    localparam logic [319:0] RLeft =
        320'h0123456789abcdef_74d1a6f3c0952eb8_3ae49f812706db5c_19ba08c4d37fe562_40597c2ae138b6fd;
    localparam logic [319:0] RRight =
        320'h5e7092b4d6f81a3c_6b370d5aef8c4912_f5137e69b8c2a04d_86413bf05c2d97ae_cfa4158762de039b;
    localparam logic [319:0] SLeft =
        320'hbefc5879bdef6798_768db97f7cf9b7dc_bd67e9dfe8d65c75_bcefef989e56865c_9f5b68dc5cdeb856;
    localparam logic [319:0] SRight =
        320'h899bdff5778beec6_9df7c89b77c76fdb_97fb866ecd5edd75_f58bee6e69c9c5f8_85c9c5e68d65fdbb;

    function automatic logic [3:0] tbl_at(logic [319:0] tbl, logic [6:0] idx);
        logic [8:0] pos;
        pos = 9'd316 - {idx, 2'b00};
        return tbl[pos +: 4];
    endfunction

    function automatic logic [31:0] k_const(logic right, logic [2:0] grp);
        logic [31:0] k;
        if (!right) begin
            case (grp)
                3'd0:    k = 32'h00000000;
                3'd1:    k = 32'h5A827999;
                3'd2:    k = 32'h6ED9EBA1;
                3'd3:    k = 32'h8F1BBCDC;
                default: k = 32'hA953FD4E;
            endcase
        end else begin
            case (grp)
                3'd0:    k = 32'h50A28BE6;
                3'd1:    k = 32'h5C4DD124;
                3'd2:    k = 32'h6D703EF3;
                3'd3:    k = 32'h7A6D76E9;
                default: k = 32'h00000000;
            endcase
        end
        return k;
    endfunction

    // sel 0..4 picks f1..f5.
    function automatic logic [31:0] f(logic [2:0] sel, logic [31:0] x, logic [31:0] y,
                                      logic [31:0] z);
        logic [31:0] r;
        case (sel)
            3'd0:    r = x ^ y ^ z;
            3'd1:    r = (x & y) | (~x & z);
            3'd2:    r = (x | ~y) ^ z;
            3'd3:    r = (x & z) | (y & ~z);
            default: r = x ^ (y | ~z);
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rol(logic [31:0] v, logic [3:0] n);
        logic [63:0] w;
        w = {v, v} << n;
        return w[63:32];
    endfunction

    function automatic logic [31:0] bswap32(logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ripemd160_line_core_round.sv
// Combinational single RIPEMD-160 round step for one line.
module ripemd160_round
    import ripemd160_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] x,
    input  logic [31:0] k,
    input  logic [3:0]  s,
    input  logic [2:0]  fsel,
    output logic [31:0] a_nxt,
    output logic [31:0] b_nxt,
    output logic [31:0] c_nxt,
    output logic [31:0] d_nxt,
    output logic [31:0] e_nxt
);

    logic [31:0] sum;
    logic [31:0] t;

    // T = rol(A + f(B,C,D) + X + K, s) + E
    always_comb begin
        sum = a + f(fsel, b, c, d) + x + k;
        t   = rol(sum, s) + e;
    end

    assign a_nxt = e;
    assign b_nxt = t;
    assign c_nxt = b;
    assign d_nxt = rol(c, 4'd10);
    assign e_nxt = d;

endmodule

// File: rtl/ripemd160_line_core.sv
// Iterative RIPEMD-160 compression of one line over a single padded 256-bit digest block.
module ripemd160_line_core
    import ripemd160_pkg::*;
#(
    parameter int unsigned LINE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [511:0] block,
    output logic         o_valid,
    output logic [159:0] ans
);

    localparam logic IsRight = (LINE != 0);

    state_e           state_q, state_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [31:0]      a_q, b_q, c_q, d_q, e_q;
    logic [31:0]      a_d, b_d, c_d, d_d, e_d;
    logic [7:0][31:0] x_q, x_d;
    logic             o_valid_q, o_valid_d;

    logic [7:0][31:0] blk_words;
    logic [3:0]       widx;
    logic [3:0]       shamt;
    logic [2:0]       grp;
    logic [2:0]       fsel;
    logic [31:0]      xw;
    logic [31:0]      kw;
    logic [31:0]      a_rnd, b_rnd, c_rnd, d_rnd, e_rnd;

    // Only the digest half of the block carries data.
    logic unused_block_hi;
    assign unused_block_hi = ^block[511:256];

    // Little-endian word loads of the digest; byte 0 sits at block[255:248].
    for (genvar gi = 0; gi < 8; gi++) begin : g_words
        assign blk_words[gi] = bswap32(block[255 - 32 * gi -: 32]);
    end

    // Schedule lookup and message word for the current round, padding words built in place.
    always_comb begin
        grp   = cnt_q[6:4];
        fsel  = IsRight ? (3'd4 - grp) : grp;
        kw    = k_const(IsRight, grp);
        widx  = IsRight ? tbl_at(RRight, cnt_q) : tbl_at(RLeft, cnt_q);
        shamt = IsRight ? tbl_at(SRight, cnt_q) : tbl_at(SLeft, cnt_q);
        if (!widx[3]) begin
            xw = x_q[widx[2:0]];
        end else if (widx == 4'd8) begin
            xw = 32'h00000080;
        end else if (widx == 4'd14) begin
            xw = 32'h00000100;
        end else begin
            xw = 32'h0;
        end
    end

    ripemd160_round u_round (
        .a     (a_q),
        .b     (b_q),
        .c     (c_q),
        .d     (d_q),
        .e     (e_q),
        .x     (xw),
        .k     (kw),
        .s     (shamt),
        .fsel  (fsel),
        .a_nxt (a_rnd),
        .b_nxt (b_rnd),
        .c_nxt (c_rnd),
        .d_nxt (d_rnd),
        .e_nxt (e_rnd)
    );

    // Next-state: accept a block in idle, one round per busy cycle, done pulse then idle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        d_d       = d_q;
        e_d       = e_q;
        x_d       = x_q;
        o_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    state_d = StBusy;
                    cnt_d   = 7'd0;
                    a_d     = IvA;
                    b_d     = IvB;
                    c_d     = IvC;
                    d_d     = IvD;
                    e_d     = IvE;
                    x_d     = blk_words;
                end
            end
            StBusy: begin
                a_d   = a_rnd;
                b_d   = b_rnd;
                c_d   = c_rnd;
                d_d   = d_rnd;
                e_d   = e_rnd;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == LastRound) begin
                    state_d = StDone;
                    cnt_d   = 7'd0;
                end
            end
            StDone: begin
                o_valid_d = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset clears the result and aborts any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 7'd0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            c_q       <= 32'h0;
            d_q       <= 32'h0;
            e_q       <= 32'h0;
            x_q       <= '0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            d_q       <= d_d;
            e_q       <= e_d;
            x_q       <= x_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_valid = o_valid_q;
    assign ans     = {a_q, b_q, c_q, d_q, e_q};

endmodule

// File: tb/tb_ripemd160_line_core.sv
// Self-checking bench: left and right line cores against a behavioural RIPEMD-160 line model.
module tb_ripemd160_line_core;

    localparam logic [255:0] DigEmpty =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [159:0] H160Empty = 160'hb472a266d0bd89c13706a4132ccfb16f7c3b9fcb;
    localparam logic [255:0] DigPub =
        256'h0b7c28c9b7290c98d7438e70b3d3f7c848fbd7d1dc194ff83f4f7cc9b1378e98;
    localparam logic [159:0] H160Pub = 160'hf54a5851e9372b87810a8e60cdd2e7cfd80b6e31;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic [511:0] block;
    logic         o_valid_l, o_valid_r;
    logic [159:0] ans_l, ans_r;

    int n_checks = 0;
    int n_errors = 0;

    int rl [80] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                    7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
                    3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
                    1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
                    4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13};
    int rr [80] = '{5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
                    6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
                    15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
                    8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
                    12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11};
    int sl [80] = '{11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
                    7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
                    11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
                    11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
                    9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6};
    int sr [80] = '{8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
                    9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
                    9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
                    15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
                    8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11};
    logic [31:0] kl [5] = '{32'h00000000, 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hA953FD4E};
    logic [31:0] kr [5] = '{32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3, 32'h7A6D76E9, 32'h00000000};

    ripemd160_line_core #(.LINE(0)) dut_l (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .block   (block),
        .o_valid (o_valid_l),
        .ans     (ans_l)
    );

    ripemd160_line_core #(.LINE(1)) dut_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .block   (block),
        .o_valid (o_valid_r),
        .ans     (ans_r)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_f(int sel, logic [31:0] x, logic [31:0] y,
                                          logic [31:0] z);
        case (sel)
            0:       return x ^ y ^ z;
            1:       return (x & y) | (~x & z);
            2:       return (x | ~y) ^ z;
            3:       return (x & z) | (y & ~z);
            default: return x ^ (y | ~z);
        endcase
    endfunction

    function automatic logic [31:0] ref_rol(logic [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] bswap(logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // One full line over the padded single block; returns {A,B,C,D,E} after round 79.
    function automatic logic [159:0] ref_line(int line, logic [255:0] dig);
        logic [31:0] xw [16];
        logic [31:0] a, b, c, d, e, t, kk, w;
        logic [7:0]  byt;
        int          g, sel, sh;
        for (int i = 0; i < 16; i++) xw[4'(i)] = 32'h0;
        for (int k = 0; k < 32; k++) begin
            byt = 8'(dig >> (8 * (31 - k)));
            xw[4'(k / 4)] = xw[4'(k / 4)] | (32'(byt) << (8 * (k % 4)));
        end
        xw[8]  = 32'h00000080;
        xw[14] = 32'h00000100;
        a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
        for (int j = 0; j < 80; j++) begin
            g = j / 16;
            if (line == 0) begin
                sel = g;     kk = kl[3'(g)]; w = xw[4'(rl[7'(j)])]; sh = sl[7'(j)];
            end else begin
                sel = 4 - g; kk = kr[3'(g)]; w = xw[4'(rr[7'(j)])]; sh = sr[7'(j)];
            end
            t = ref_rol(a + ref_f(sel, b, c, d) + w + kk, sh) + e;
            a = e; e = d; d = ref_rol(c, 10); c = b; b = t;
        end
        return {a, b, c, d, e};
    endfunction

    function automatic logic [159:0] combine(logic [159:0] l, logic [159:0] r);
        logic [31:0] al, bl, cl, dl, el, ar, br, cr, dr, er;
        {al, bl, cl, dl, el} = l;
        {ar, br, cr, dr, er} = r;
        return {bswap(32'hEFCDAB89 + cl + dr), bswap(32'h98BADCFE + dl + er),
                bswap(32'h10325476 + el + ar), bswap(32'hC3D2E1F0 + al + br),
                bswap(32'h67452301 + bl + cr)};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom())};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse i_valid for the next edge with the digest in the low half and junk above it.
    task automatic start(input logic [255:0] dig);
        block   = {rand256(), dig};
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        block   = {rand256(), rand256()};
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 120; n++) begin
            tick();
            if (o_valid_l === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_block(input string tag, input logic [255:0] dig);
        int lat;
        start(dig);
        wait_done(lat);
        chk({tag, "_latency"}, 160'(lat), 160'(81));
        chk({tag, "_ovalid_r"}, 160'(o_valid_r), 160'(1));
        chk({tag, "_ans_l"}, ans_l, ref_line(0, dig));
        chk({tag, "_ans_r"}, ans_r, ref_line(1, dig));
    endtask

    initial begin
        logic [255:0] d1, d2;
        int           lat;
        logic         seen;

        rst_n   = 1'b0;
        i_valid = 1'b0;
        block   = '0;
        repeat (3) tick();
        chk("rst_ovalid_l", 160'(o_valid_l), 160'(0));
        chk("rst_ovalid_r", 160'(o_valid_r), 160'(0));
        chk("rst_ans_l", ans_l, 160'h0);
        chk("rst_ans_r", ans_r, 160'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Hash160 of the empty string, then pulse width and idle hold.
        run_block("empty", DigEmpty);
        chk("empty_hash160", combine(ans_l, ans_r), H160Empty);
        tick();
        chk("pulse_width_l", 160'(o_valid_l), 160'(0));
        chk("pulse_width_r", 160'(o_valid_r), 160'(0));
        for (int i = 0; i < 10; i++) begin
            block = {rand256(), rand256()};
            tick();
            chk("idle_hold_l", ans_l, ref_line(0, DigEmpty));
        end
        chk("idle_hold_r", ans_r, ref_line(1, DigEmpty));

        // Bitcoin public-key digest.
        run_block("pubkey", DigPub);
        chk("pubkey_hash160", combine(ans_l, ans_r), H160Pub);
        tick();

        // Second start while busy is dropped.
        d1 = rand256();
        d2 = rand256();
        start(d1);
        repeat (39) tick();
        start(d2);
        wait_done(lat);
        chk("busy_latency", 160'(lat), 160'(41));
        chk("busy_ans_l", ans_l, ref_line(0, d1));
        chk("busy_ans_r", ans_r, ref_line(1, d1));
        tick();

        // Asynchronous reset in the middle of a run.
        start(rand256());
        repeat (29) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ovalid", 160'(o_valid_l), 160'(0));
        chk("midrst_ans_l", ans_l, 160'h0);
        chk("midrst_ans_r", ans_r, 160'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 90; i++) begin
            tick();
            seen = seen | o_valid_l | o_valid_r;
        end
        chk("midrst_no_ovalid", 160'(seen), 160'(0));
        run_block("after_rst", rand256());
        tick();

        // Back-to-back: new start raised while o_valid is high.
        d1 = rand256();
        d2 = rand256();
        run_block("b2b_first", d1);
        start(d2);
        wait_done(lat);
        chk("b2b_gap", 160'(lat + 1), 160'(82));
        chk("b2b_ans_l", ans_l, ref_line(0, d2));
        chk("b2b_ans_r", ans_r, ref_line(1, d2));
        tick();

        // Random digests.
        for (int i = 0; i < 3; i++) begin
            run_block("random", rand256());
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
